fg_prog_sequencer: RTL



---
 rtl/fg_prog_pkg.sv | 28 ++
 rtl/fg_pulse_timer.sv | 32 +++
 rtl/fg_prog_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fg_prog_pkg.sv
// fg_prog_pkg: shared types and default constants for the floating-gate
// island programming sequencer.
//   state_t  - sequencer FSM states (also exported on the debug port)
//   status_t - completion status reported with done_valid
//   DEF_*    - default geometry and settle length of one island
package fg_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_MEASURE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_ABORT   = 2'b10,
    STAT_BADADDR = 2'b11
  } status_t;

  localparam int DEF_SETTLE   = 8;
  localparam int DEF_NUM_ROWS = 9;
  localparam int DEF_NUM_COLS = 18;

endpackage

// File: rtl/fg_pulse_timer.sv
// fg_pulse_timer: loadable down-counter with a zero flag. One instance times
// the SETUP settle, the injection pulse and the RECOVER settle in turn.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - value to load; the interval lasts load_val+1 cycles
//   zero       - counter is at zero (last cycle of the interval)
module fg_pulse_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// fg_prog_sequencer: programming sequencer for one indirectly programmed
// floating-gate island. Latches one command, drives the decoder addresses and
// prog-switch enable, issues hot-electron injection pulses and polls an
// external measurement engine between pulses.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   cmd_valid/cmd_ready        - command handshake
//   cmd_row/col/pulses/width   - command fields, latched at acceptance
//   abort                      - terminate the running command
//   meas_req/meas_ack/meas_hit - measurement engine handshake
//   row_addr/col_addr          - vertical / horizontal decoder addresses
//   prog_mode                  - prog-switch / drain-select enable
//   vinj_pulse                 - injection enable
//   done_valid/status/count    - one-cycle completion record
//   dbg_state                  - current FSM state, for observation only
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while idle, so the command
// fields must be stable during that cycle only. meas_req is a level held
// until the engine answers with a single-cycle meas_ack (meas_hit qualified
// by meas_ack); meas_ack while meas_req is low is ignored.
//
// Every output is a register loaded from the *next* state, so an output that
// belongs to a state is visible exactly during the cycles spent in it.
module fg_prog_sequencer
  import fg_prog_pkg::*;
#(
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int NUM_COLS   = DEF_NUM_COLS,
  parameter int ADDR_BITS  = 6,
  parameter int WIDTH_BITS = 16,
  parameter int CNT_BITS   = 8,
  parameter int SETTLE     = DEF_SETTLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_BITS-1:0]  cmd_row,
  input  logic [ADDR_BITS-1:0]  cmd_col,
  input  logic [CNT_BITS-1:0]   cmd_pulses,
  input  logic [WIDTH_BITS-1:0] cmd_width,
  input  logic                  abort,
  output logic                  meas_req,
  input  logic                  meas_ack,
  input  logic                  meas_hit,
  output logic [ADDR_BITS-1:0]  row_addr,
  output logic [ADDR_BITS-1:0]  col_addr,
  output logic                  prog_mode,
  output logic                  vinj_pulse,
  output logic                  done_valid,
  output logic [1:0]            done_status,
  output logic [CNT_BITS-1:0]   done_count,
  output logic [2:0]            dbg_state
);

  localparam logic [ADDR_BITS-1:0]  ROW_LIM    = ADDR_BITS'(NUM_ROWS);
  localparam logic [ADDR_BITS-1:0]  COL_LIM    = ADDR_BITS'(NUM_COLS);
  localparam logic [WIDTH_BITS-1:0] SETTLE_LD  = WIDTH_BITS'(SETTLE - 1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX    = '1;

  state_t                state, state_next;
  status_t               stat_next;

  logic [ADDR_BITS-1:0]  row_q, col_q;
  logic [CNT_BITS-1:0]   pulses_q, cnt_q;
  logic [WIDTH_BITS-1:0] width_q;
  logic                  bad_q;

  logic                  accept;
  logic                  cmd_bad;
  logic                  tmr_load;
  logic [WIDTH_BITS-1:0] tmr_val;
  logic                  tmr_zero;

  // Output register inputs
  logic                  cmd_ready_d, meas_req_d, prog_mode_d, vinj_pulse_d;
  logic                  done_valid_d;
  logic [ADDR_BITS-1:0]  row_addr_d, col_addr_d;
  logic [1:0]            done_status_d;
  logic [CNT_BITS-1:0]   done_count_d;
  logic [ADDR_BITS-1:0]  row_eff, col_eff;
  logic                  bad_eff, active;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign cmd_bad   = (cmd_row >= ROW_LIM) || (cmd_col >= COL_LIM);
  assign dbg_state = state;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------- next-state comb
  // A bad address still passes through one SETUP cycle with all island
  // outputs suppressed; it is rejected from there.
  always_comb begin
    state_next = state;
    stat_next  = STAT_OK;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (abort) begin
          state_next = ST_DONE;
          stat_next  = STAT_ABORT;
        end else if (bad_q) begin
          state_next = ST_DONE;
          stat_next  = STAT_BADADDR;
        end else if (tmr_zero) begin
          state_next = (pulses_q == '0) ? ST_MEASURE : ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (abort) begin
          state_next = ST_DONE;
          stat_next  = STAT_ABORT;
        end else if (tmr_zero) begin
          state_next = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (abort) begin
          state_next = ST_DONE;
          stat_next  = STAT_ABORT;
        end else if (tmr_zero) begin
          state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        // abort wins over an acknowledge in the same cycle
        if (abort) begin
          state_next = ST_DONE;
          stat_next  = STAT_ABORT;
        end else if (meas_ack) begin
          if (meas_hit) begin
            state_next = ST_DONE;
            stat_next  = STAT_OK;
          end else if (cnt_q == pulses_q) begin
            state_next = ST_DONE;
            stat_next  = STAT_TIMEOUT;
          end else begin
            state_next = ST_PULSE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ interval timer
  // Loaded on entry to each timed state with (duration - 1).
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_next != state) begin
      case (state_next)
        ST_SETUP, ST_RECOVER: begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
        ST_PULSE: begin
          tmr_load = 1'b1;
          tmr_val  = (width_q == '0) ? '0 : width_q - WIDTH_BITS'(1);
        end
        default: begin
          tmr_load = 1'b0;
          tmr_val  = '0;
        end
      endcase
    end
  end

  fg_pulse_timer #(.W(WIDTH_BITS)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // ------------------------------------------------ command latch and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_q    <= '0;
      pulses_q <= '0;
      width_q  <= '0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      row_q    <= cmd_row;
      col_q    <= cmd_col;
      pulses_q <= cmd_pulses;
      width_q  <= cmd_width;
      bad_q    <= cmd_bad;
      cnt_q    <= '0;
    end else if (state == ST_PULSE && state_next == ST_RECOVER &&
                 cnt_q != CNT_MAX) begin
      // only a pulse that ran to completion is counted; saturates
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  // -------------------------------------------------------------- output comb
  // On acceptance the latch is loading in the same edge, so take the command
  // fields straight from the inputs.
  always_comb begin
    row_eff       = accept ? cmd_row : row_q;
    col_eff       = accept ? cmd_col : col_q;
    bad_eff       = accept ? cmd_bad : bad_q;
    active        = !bad_eff && (state_next == ST_SETUP   ||
                                 state_next == ST_PULSE   ||
                                 state_next == ST_RECOVER ||
                                 state_next == ST_MEASURE);
    cmd_ready_d   = (state_next == ST_IDLE);
    prog_mode_d   = active;
    row_addr_d    = active ? row_eff : '0;
    col_addr_d    = active ? col_eff : '0;
    vinj_pulse_d  = (state_next == ST_PULSE);
    meas_req_d    = (state_next == ST_MEASURE);
    done_valid_d  = (state_next == ST_DONE);
    done_status_d = (state_next == ST_DONE) ? stat_next : 2'b00;
    done_count_d  = (state_next == ST_DONE) ? cnt_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready   <= 1'b1;
      prog_mode   <= 1'b0;
      row_addr    <= '0;
      col_addr    <= '0;
      vinj_pulse  <= 1'b0;
      meas_req    <= 1'b0;
      done_valid  <= 1'b0;
      done_status <= 2'b00;
      done_count  <= '0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      prog_mode   <= prog_mode_d;
      row_addr    <= row_addr_d;
      col_addr    <= col_addr_d;
      vinj_pulse  <= vinj_pulse_d;
      meas_req    <= meas_req_d;
      done_valid  <= done_valid_d;
      done_status <= done_status_d;
      done_count  <= done_count_d;
    end
  end

endmodule
